// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU with iterative multiply/divide into HI/LO and HI/LO hazard stall.
// Define ALU_MULDIV_DIV_EN to compile in the divider; otherwise div/divu are no-ops.
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       ALUcontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             stall
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
`ifdef ALU_MULDIV_DIV_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_opb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
`ifdef ALU_MULDIV_DIV_EN
  logic             r_is_div, r_dz, r_neg_r;
`endif

  logic             w_rtype, w_is_mul, w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
  logic             w_hilo_cls, w_accept, w_start_mul, w_last;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_alu;
  logic             w_lt_s, w_lt_u;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi_n, w_mul_lo_n;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0] w_step_hi, w_step_lo, w_fin_hi, w_fin_lo;
`ifdef ALU_MULDIV_DIV_EN
  logic             w_is_div, w_start_div, w_b_zero, w_ge;
  logic [WIDTH:0]   w_shift, w_trial;
  logic [WIDTH-1:0] w_div_hi_n, w_div_lo_n;
`endif

  // Instruction class decode
  assign w_rtype    = (ALUOp == 2'b10);
  assign w_is_mul   = w_rtype && (funct == F_MULT || funct == F_MULTU);
  assign w_is_mfhi  = w_rtype && (funct == F_MFHI);
  assign w_is_mflo  = w_rtype && (funct == F_MFLO);
  assign w_is_mthi  = w_rtype && (funct == F_MTHI);
  assign w_is_mtlo  = w_rtype && (funct == F_MTLO);
`ifdef ALU_MULDIV_DIV_EN
  assign w_is_div   = w_rtype && (funct == F_DIV || funct == F_DIVU);
  assign w_hilo_cls = w_is_mul | w_is_div | w_is_mfhi | w_is_mflo | w_is_mthi | w_is_mtlo;
`else
  assign w_hilo_cls = w_is_mul | w_is_mfhi | w_is_mflo | w_is_mthi | w_is_mtlo;
`endif

  assign busy        = (r_state == S_RUN);
  assign stall       = in_valid & w_hilo_cls & busy;
  assign w_accept    = in_valid & w_hilo_cls & ~busy;
  assign w_start_mul = w_accept & w_is_mul;
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

  // funct[0] clear selects the signed variant of mult/div
  assign w_a_neg = ~funct[0] & a[WIDTH-1];
  assign w_b_neg = ~funct[0] & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  always_comb begin
    ALUcontrol = 4'b0010;
    case (ALUOp)
      2'b00: ALUcontrol = 4'b0010;
      2'b01: ALUcontrol = 4'b0110;
      2'b11: ALUcontrol = 4'b0001;
      default: begin
        case (funct)
          F_ADD:   ALUcontrol = 4'b0010;
          F_SUB:   ALUcontrol = 4'b0110;
          F_AND:   ALUcontrol = 4'b0000;
          F_OR:    ALUcontrol = 4'b0001;
          F_XOR:   ALUcontrol = 4'b0011;
          F_NOR:   ALUcontrol = 4'b1100;
          F_SLT:   ALUcontrol = 4'b0111;
          F_SLTU:  ALUcontrol = 4'b1000;
          default: ALUcontrol = 4'b0010;
        endcase
      end
    endcase
  end

  assign w_lt_s = ($signed(a) < $signed(b));
  assign w_lt_u = (a < b);

  always_comb begin
    w_alu = a + b;
    case (ALUcontrol)
      4'b0000: w_alu = a & b;
      4'b0001: w_alu = a | b;
      4'b0011: w_alu = a ^ b;
      4'b0110: w_alu = a - b;
      4'b0111: w_alu = {{(WIDTH-1){1'b0}}, w_lt_s};
      4'b1000: w_alu = {{(WIDTH-1){1'b0}}, w_lt_u};
      4'b1100: w_alu = ~(a | b);
      default: w_alu = a + b;
    endcase
  end

  always_comb begin
    result = w_alu;
    if (w_is_mfhi)      result = r_hi;
    else if (w_is_mflo) result = r_lo;
  end

  assign zero = (result == '0);

  // Shift-add multiply: r_acc_hi accumulates, r_acc_lo holds the shrinking multiplier
  assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_hi_n = w_mul_sum[WIDTH:1];
  assign w_mul_lo_n = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
  assign w_prod     = {w_mul_hi_n, w_mul_lo_n};
  assign w_prod_s   = r_neg_q ? -w_prod : w_prod;

`ifdef ALU_MULDIV_DIV_EN
  // Restoring divide: r_acc_hi is the partial remainder, r_acc_lo shifts dividend out, quotient in
  assign w_start_div = w_accept & w_is_div;
  assign w_b_zero    = (b == '0);
  assign w_shift     = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_trial     = w_shift - {1'b0, r_opb};
  assign w_ge        = ~w_trial[WIDTH];
  assign w_div_hi_n  = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_lo_n  = {r_acc_lo[WIDTH-2:0], w_ge};
`endif

  always_comb begin
    w_step_hi = w_mul_hi_n;
    w_step_lo = w_mul_lo_n;
    w_fin_hi  = w_prod_s[2*WIDTH-1:WIDTH];
    w_fin_lo  = w_prod_s[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
    if (r_is_div) begin
      if (r_dz) begin
        // r_acc_hi holds the raw dividend for the divide-by-zero result
        w_step_hi = r_acc_hi;
        w_step_lo = r_acc_lo;
        w_fin_hi  = r_acc_hi;
        w_fin_lo  = '1;
      end else begin
        w_step_hi = w_div_hi_n;
        w_step_lo = w_div_lo_n;
        w_fin_hi  = r_neg_r ? -w_div_hi_n : w_div_hi_n;
        w_fin_lo  = r_neg_q ? -w_div_lo_n : w_div_lo_n;
      end
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef ALU_MULDIV_DIV_EN
        if (w_start_mul || w_start_div) w_state_nxt = S_RUN;
`else
        if (w_start_mul) w_state_nxt = S_RUN;
`endif
      end
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      if (w_accept && w_is_mthi) r_hi <= a;
      if (w_accept && w_is_mtlo) r_lo <= a;
      if (w_start_mul) begin
        r_acc_hi <= '0;
        r_acc_lo <= w_a_mag;
        r_opb    <= w_b_mag;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_cnt    <= '0;
`ifdef ALU_MULDIV_DIV_EN
        r_is_div <= 1'b0;
        r_dz     <= 1'b0;
`endif
      end
`ifdef ALU_MULDIV_DIV_EN
      if (w_start_div) begin
        r_acc_hi <= w_b_zero ? a : '0;
        r_acc_lo <= w_a_mag;
        r_opb    <= w_b_mag;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_is_div <= 1'b1;
        r_dz     <= w_b_zero;
        r_cnt    <= '0;
      end
`endif
      if (busy) begin
        r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
        if (w_last) begin
          r_hi <= w_fin_hi;
          r_lo <= w_fin_lo;
        end
      end
    end
  end

endmodule
